trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap/return sequencer that sits directly upstream of the machine-mode CSR file.
- Accepts one retiring system-class instruction per handshake from EXU: ecall, ebreak, illegal or mret.
- For traps, drives the CSR file's trap-entry strobe (intr, intr_NO, intr_epc). For mret, drives a CSR write to restore mstatus.
- Then issues a single PC redirect (mtvec or mepc) to IFU and holds it until IFU accepts.

Parameters:
- DATA_WIDTH, 32, width of PC, CSR data and CSR address buses.
- CAUSE_ILLEGAL, 2, mcause value for an illegal instruction.
- CAUSE_BREAK, 3, mcause value for ebreak.
- CAUSE_ECALL, 11, mcause value for ecall from M-mode.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EXU presents an instruction.
- in_ready  out  1  block can accept.
- in_pc  in  DATA_WIDTH  PC of the presented instruction.
- in_ecall / in_ebreak / in_illegal / in_mret  in  1 each  decoded class flags.
- intr  out  1  trap-entry strobe to the CSR file.
- intr_NO  out  DATA_WIDTH  cause value to the CSR file.
- intr_epc  out  DATA_WIDTH  faulting PC to the CSR file.
- csr_wen  out  1  CSR write enable (mret mstatus restore).
- csr_addr  out  DATA_WIDTH  CSR write address.
- csr_wdata  out  DATA_WIDTH  CSR write data.
- mtvec / mepc / mstatus  in  DATA_WIDTH each  current CSR values.
- redirect_valid  out  1  redirect request to IFU.
- redirect_ready  in  1  IFU accepts the redirect.
- redirect_pc  out  DATA_WIDTH  redirect target.
- trap_cnt  out  DATA_WIDTH  count of trap entries taken.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state is IDLE; latched pc, cause and target are 0; trap_cnt is 0.
  - While rst is high, in_ready, intr, csr_wen and redirect_valid are 0; intr_NO, intr_epc, csr_addr, csr_wdata and redirect_pc are 0.
  - Reset mid-sequence abandons it: no further intr/csr_wen pulse, and any pending redirect is dropped.
- States: IDLE, TRAP, MRET, REDIR. All outputs are decoded from state and latched registers only; there is no input-to-output combinational path except in_ready, which is driven from state.
- IDLE:
  - in_ready=1.
  - Acceptance occurs on in_valid & in_ready. On acceptance, latch in_pc and select the class by priority: illegal > ebreak > ecall > mret.
  - Trap class: latch cause (CAUSE_ILLEGAL, CAUSE_BREAK or CAUSE_ECALL); next state TRAP.
  - mret only: next state MRET.
  - No flag set: the instruction is consumed as a no-op and the block stays in IDLE.
- TRAP (exactly 1 cycle):
  - intr=1, intr_NO=latched cause, intr_epc=latched pc; csr_wen=0. The CSR file gives wen priority over intr, so wen must be low here.
  - Latch target={mtvec[DATA_WIDTH-1:2],2'b00} (direct mode only; mode bits ignored).
  - trap_cnt increments by 1, wrapping at 2^DATA_WIDTH.
  - Next state REDIR.
- MRET (exactly 1 cycle):
  - csr_wen=1, csr_addr=0x300.
  - csr_wdata = mstatus with bit3 := mstatus[7], bit7 := 1, bits[12:11] := 2'b00; all other bits unchanged.
  - intr=0. Latch target=mepc.
  - Next state REDIR.
- REDIR:
  - redirect_valid=1, redirect_pc=target. Both hold stable until redirect_ready is sampled high.
  - In the handshake cycle (redirect_valid & redirect_ready), next state IDLE. in_ready returns 1 the cycle after.
- Latency: accept at edge N → intr or csr_wen high in cycle N+1 → redirect_valid first high in cycle N+2.
- Throughput: at most one sequence in flight; in_ready=0 in TRAP, MRET and REDIR.
- intr and csr_wen are never high in the same cycle.
- Width: all arithmetic is DATA_WIDTH bits, unsigned. Cause constants are zero-extended.

Test Plan:
- Reset, then ecall at pc=0x80000010 with mtvec=0x80000101:
  - cycle+1: intr=1, intr_NO=11, intr_epc=0x80000010.
  - cycle+2: redirect_valid=1, redirect_pc=0x80000100; trap_cnt=1.
- mret with mstatus=0x00001880, mepc=0x80000014, redirect_ready=1:
  - csr_wen=1, csr_addr=0x300, csr_wdata=0x00000088; intr=0.
  - redirect_pc=0x80000014; back to IDLE the cycle after the handshake.
- in_illegal, in_ecall and in_mret all high together → intr_NO=2; no csr_wen pulse.
- redirect_ready low for 5 cycles → redirect_valid and redirect_pc stable all 5 cycles; in_ready=0; in_valid pulses during this window are not accepted.
- rst asserted in the TRAP cycle → the next cycle has intr=0, redirect_valid=0, trap_cnt=0, state IDLE.
- trap_cnt preloaded near wrap via 2^DATA_WIDTH traps (or forced to 0xFFFFFFFF) → one more ebreak gives trap_cnt=0 and intr_NO=3.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/return sequencer feeding the machine-mode CSR file.
// Sequences ecall/ebreak/illegal/mret into a CSR update plus one IFU redirect.
module trap_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CAUSE_ILLEGAL = 2,
  parameter int unsigned CAUSE_BREAK   = 3,
  parameter int unsigned CAUSE_ECALL   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  in_ecall,
  input  logic                  in_ebreak,
  input  logic                  in_illegal,
  input  logic                  in_mret,
  output logic                  intr,
  output logic [DATA_WIDTH-1:0] intr_NO,
  output logic [DATA_WIDTH-1:0] intr_epc,
  output logic                  csr_wen,
  output logic [DATA_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] mepc,
  input  logic [DATA_WIDTH-1:0] mstatus,
  output logic                  redirect_valid,
  input  logic                  redirect_ready,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] trap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    MRET,
    REDIR
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] cnt_q;

  logic                  accept;
  logic                  is_trap;
  logic [DATA_WIDTH-1:0] cause_d;
  logic [DATA_WIDTH-1:0] mret_wdata;

  assign accept = in_valid & in_ready;

  always_comb begin
    is_trap = 1'b1;
    cause_d = '0;
    if (in_illegal) begin
      cause_d = DATA_WIDTH'(CAUSE_ILLEGAL);
    end else if (in_ebreak) begin
      cause_d = DATA_WIDTH'(CAUSE_BREAK);
    end else if (in_ecall) begin
      cause_d = DATA_WIDTH'(CAUSE_ECALL);
    end else begin
      is_trap = 1'b0;
    end
  end

  // MIE <= MPIE, MPIE <= 1, MPP <= U
  always_comb begin
    mret_wdata        = mstatus;
    mret_wdata[3]     = mstatus[7];
    mret_wdata[7]     = 1'b1;
    mret_wdata[12:11] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_trap) begin
          state_d = TRAP;
        end else if (accept && in_mret) begin
          state_d = MRET;
        end
      end
      TRAP:  state_d = REDIR;
      MRET:  state_d = REDIR;
      REDIR: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            pc_q    <= in_pc;
            cause_q <= cause_d;
            wdata_q <= mret_wdata;
          end
        end
        TRAP: begin
          target_q <= mtvec & ~DATA_WIDTH'(3);
          cnt_q    <= cnt_q + 1'b1;
        end
        MRET: begin
          target_q <= mepc;
        end
        default: ;
      endcase
    end
  end

  // Outputs come from state and registers; rst forces them quiet.
  always_comb begin
    in_ready       = 1'b0;
    intr           = 1'b0;
    intr_NO        = '0;
    intr_epc       = '0;
    csr_wen        = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: in_ready = 1'b1;
        TRAP: begin
          intr     = 1'b1;
          intr_NO  = cause_q;
          intr_epc = pc_q;
        end
        MRET: begin
          csr_wen   = 1'b1;
          csr_addr  = DATA_WIDTH'(12'h300);
          csr_wdata = wdata_q;
        end
        REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
        end
        default: ;
      endcase
    end
  end

  assign trap_cnt = cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed vectors push expectations,
// a negedge monitor pops them as the CSR/redirect strobes appear.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic        in_ecall = 1'b0;
  logic        in_ebreak = 1'b0;
  logic        in_illegal = 1'b0;
  logic        in_mret = 1'b0;
  logic        intr;
  logic [31:0] intr_NO;
  logic [31:0] intr_epc;
  logic        csr_wen;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] mtvec = '0;
  logic [31:0] mepc = '0;
  logic [31:0] mstatus = '0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b1;
  logic [31:0] redirect_pc;
  logic [31:0] trap_cnt;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_ecall(in_ecall), .in_ebreak(in_ebreak),
    .in_illegal(in_illegal), .in_mret(in_mret),
    .intr(intr), .intr_NO(intr_NO), .intr_epc(intr_epc),
    .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    q.push_back(e);
  endtask

  // Monitor: kind 0 = intr, 1 = csr write, 2 = redirect handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (intr && csr_wen) chk("intr_wen_overlap", 32'd1, 32'd0);
      if (intr) begin
        if (q.size() == 0) chk("unexpected_intr", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("intr_kind", 32'd0, e.kind);
          chk("intr_NO", intr_NO, e.a);
          chk("intr_epc", intr_epc, e.b);
        end
      end
      if (csr_wen) begin
        if (q.size() == 0) chk("unexpected_wen", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("wen_kind", 32'd1, e.kind);
          chk("csr_addr", csr_addr, 32'h300);
          chk("csr_wdata", csr_wdata, e.a);
        end
      end
      if (redirect_valid && redirect_ready) begin
        if (q.size() == 0) chk("unexpected_redir", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("redir_kind", 32'd2, e.kind);
          chk("redirect_pc", redirect_pc, e.a);
          chk("trap_cnt", trap_cnt, e.b);
        end
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [3:0] fl);
    @(negedge clk);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_illegal = fl[3];
    in_ebreak  = fl[2];
    in_ecall   = fl[1];
    in_mret    = fl[0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {in_illegal, in_ebreak, in_ecall, in_mret} = 4'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready && q.size() == 0) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_trap_cnt", trap_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // ecall, mtvec mode bits masked
    mtvec = 32'h80000101;
    push(0, 32'd11, 32'h80000010);
    push(2, 32'h80000100, 32'd1);
    send(32'h80000010, 4'b0010);
    drain("ecall_drain");

    // mret restores mstatus
    mstatus = 32'h00001880;
    mepc    = 32'h80000014;
    push(1, 32'h00000088, 32'd0);
    push(2, 32'h80000014, 32'd1);
    send(32'h80000020, 4'b0001);
    drain("mret_drain");

    // priority: illegal wins, no csr write
    mtvec = 32'h00001003;
    push(0, 32'd2, 32'h00000200);
    push(2, 32'h00001000, 32'd2);
    send(32'h00000200, 4'b1011);
    drain("prio_drain");

    // no-op consume
    send(32'h00000210, 4'b0000);
    @(negedge clk);
    chk("noop_in_ready", 32'(in_ready), 32'd1);

    // redirect stall with in_valid pulses
    redirect_ready = 1'b0;
    push(0, 32'd11, 32'h00000300);
    push(2, 32'h00001000, 32'd3);
    send(32'h00000300, 4'b0010);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (redirect_valid) seen = 1'b1;
    end
    chk("stall_redir_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_ecall = 1'b1;
      in_pc    = 32'h00000999;
      chk("stall_valid", 32'(redirect_valid), 32'd1);
      chk("stall_pc", redirect_pc, 32'h00001000);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_ecall = 1'b0;
    redirect_ready = 1'b1;
    drain("stall_drain");

    // reset during TRAP abandons the sequence
    send(32'h00000400, 4'b0100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_intr", 32'(intr), 32'd0);
    chk("rstmid_redir", 32'(redirect_valid), 32'd0);
    chk("rstmid_cnt", trap_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rstmid_no_redir", 32'(redirect_valid), 32'd0);

    // counter wrap
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    @(negedge clk);
    chk("preload_cnt", trap_cnt, 32'hFFFFFFFF);
    push(0, 32'd3, 32'h00000500);
    push(2, 32'h00001000, 32'd0);
    send(32'h00000500, 4'b0100);
    drain("wrap_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
